// File: rtl/spi_slave_fifo_pkg.sv
// Shared constants and sizing helpers for the synchronous FIFO.
// Holds default depth/thresholds and the level/pointer width functions.
package spi_slave_fifo_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_DEPTH      = 8;
  localparam int DEF_AFULL      = 6;
  localparam int DEF_AEMPTY     = 2;

  function automatic int lvl_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/spi_slave_fifo_mem.sv
// FIFO storage: one synchronous write port, one async read port, no reset.
// Ports: clk, we_i, waddr_i, wdata_i, raddr_i, rdata_o.
module spi_slave_fifo_mem
  import spi_slave_fifo_pkg::*;
#(
  parameter int DW    = DEF_DATA_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = ptr_w(DEF_DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/spi_slave_sync_fifo.sv
// Synchronous valid/ready FIFO with level and almost-full/empty flags.
// Ports: clk, rstn, clr_i, data_i/valid_i/ready_o (write side),
//   data_o/valid_o/ready_i (read side), level_o, afull_o, aempty_o.
// Define SPI_SLAVE_FIFO_ERR_EN to add sticky ovf_o/udf_o error flags.
module spi_slave_sync_fifo
  import spi_slave_fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int BUFFER_DEPTH  = DEF_DEPTH,
  parameter int AFULL_THRESH  = DEF_AFULL,
  parameter int AEMPTY_THRESH = DEF_AEMPTY
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           clr_i,
  input  logic [DATA_WIDTH-1:0]          data_i,
  input  logic                           valid_i,
  output logic                           ready_o,
  output logic [DATA_WIDTH-1:0]          data_o,
  output logic                           valid_o,
  input  logic                           ready_i,
  output logic [lvl_w(BUFFER_DEPTH)-1:0] level_o,
  output logic                           afull_o,
`ifdef SPI_SLAVE_FIFO_ERR_EN
  output logic                           ovf_o,
  output logic                           udf_o,
`endif
  output logic                           aempty_o
);

  localparam int LW = lvl_w(BUFFER_DEPTH);
  localparam int PW = ptr_w(BUFFER_DEPTH);

  localparam logic [LW-1:0] FULL_L   = LW'(BUFFER_DEPTH);
  localparam logic [LW-1:0] AFULL_L  = LW'(AFULL_THRESH);
  localparam logic [LW-1:0] AEMPTY_L = LW'(AEMPTY_THRESH);
  localparam logic [PW-1:0] LAST_P   = PW'(BUFFER_DEPTH - 1);

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          push, pop;

  // Explicit wrap keeps non-power-of-two depths in range.
  function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
    return (p == LAST_P) ? '0 : p + 1'b1;
  endfunction

  assign ready_o  = (level_q < FULL_L);
  assign valid_o  = (level_q != '0);
  assign afull_o  = (level_q >= AFULL_L);
  assign aempty_o = (level_q <= AEMPTY_L);
  assign level_o  = level_q;

  assign push = valid_i && ready_o;
  assign pop  = valid_o && ready_i;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (clr_i) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (push) wptr_d = inc_ptr(wptr_q);
      if (pop)  rptr_d = inc_ptr(rptr_q);
    end
    unique case (1'b1)
      clr_i:                    level_d = '0;
      !clr_i && push && !pop:   level_d = level_q + 1'b1;
      !clr_i && pop && !push:   level_d = level_q - 1'b1;
      default:                  level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

`ifdef SPI_SLAVE_FIFO_ERR_EN
  logic ovf_q, ovf_d;
  logic udf_q, udf_d;

  always_comb begin
    ovf_d = ovf_q | (valid_i & ~ready_o);
    udf_d = udf_q | (ready_i & ~valid_o);
    if (clr_i) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign ovf_o = ovf_q;
  assign udf_o = udf_q;
`endif

  spi_slave_fifo_mem #(
    .DW    (DATA_WIDTH),
    .DEPTH (BUFFER_DEPTH),
    .AW    (PW)
  ) u_mem (
    .clk     (clk),
    .we_i    (push && !clr_i),
    .waddr_i (wptr_q),
    .wdata_i (data_i),
    .raddr_i (rptr_q),
    .rdata_o (data_o)
  );

endmodule

// File: tb/tb_spi_slave_sync_fifo.sv
// Directed bench for spi_slave_sync_fifo: vector table plus corner sequences.
// Covers depth 8 (default) and a depth-5 instance.
module tb_spi_slave_sync_fifo;

  logic        clk = 1'b0;
  logic        rstn;
  logic        clr;
  logic [31:0] din;
  logic        vin;
  logic        rdy;
  logic [31:0] dout;
  logic        vout;
  logic        rin;
  logic [3:0]  lvl;
  logic        af;
  logic        ae;

  logic        clr5;
  logic [7:0]  d5;
  logic        v5;
  logic        rdy5;
  logic [7:0]  dout5;
  logic        vout5;
  logic        r5;
  logic [2:0]  lvl5;
  logic        af5;
  logic        ae5;

`ifdef SPI_SLAVE_FIFO_ERR_EN
  logic ovf, udf, ovf5, udf5;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  spi_slave_sync_fifo dut (
    .clk      (clk),
    .rstn     (rstn),
    .clr_i    (clr),
    .data_i   (din),
    .valid_i  (vin),
    .ready_o  (rdy),
    .data_o   (dout),
    .valid_o  (vout),
    .ready_i  (rin),
    .level_o  (lvl),
    .afull_o  (af),
`ifdef SPI_SLAVE_FIFO_ERR_EN
    .ovf_o    (ovf),
    .udf_o    (udf),
`endif
    .aempty_o (ae)
  );

  spi_slave_sync_fifo #(
    .DATA_WIDTH    (8),
    .BUFFER_DEPTH  (5),
    .AFULL_THRESH  (4),
    .AEMPTY_THRESH (1)
  ) dut5 (
    .clk      (clk),
    .rstn     (rstn),
    .clr_i    (clr5),
    .data_i   (d5),
    .valid_i  (v5),
    .ready_o  (rdy5),
    .data_o   (dout5),
    .valid_o  (vout5),
    .ready_i  (r5),
    .level_o  (lvl5),
    .afull_o  (af5),
`ifdef SPI_SLAVE_FIFO_ERR_EN
    .ovf_o    (ovf5),
    .udf_o    (udf5),
`endif
    .aempty_o (ae5)
  );

  typedef struct {
    logic        clr;
    logic        vin;
    logic [31:0] din;
    logic        rin;
    logic [3:0]  lvl;
    logic        vout;
    logic [31:0] dout;
    logic        rdy;
    logic        af;
    logic        ae;
  } vec_t;

  vec_t tbl[20];

  function automatic vec_t mk(
    input logic c, input logic v, input logic [31:0] d, input logic r,
    input logic [3:0] l, input logic vo, input logic [31:0] dq,
    input logic ro, input logic a_f, input logic a_e
  );
    vec_t t;
    t.clr = c; t.vin = v; t.din = d; t.rin = r;
    t.lvl = l; t.vout = vo; t.dout = dq;
    t.rdy = ro; t.af = a_f; t.ae = a_e;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic push_n(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      vin = 1'b1;
      din = base + 32'(i);
    end
    @(negedge clk);
    vin = 1'b0;
  endtask

  task automatic clr_cycle();
    @(negedge clk);
    clr = 1'b1; vin = 1'b0; rin = 1'b0;
    @(negedge clk);
    clr = 1'b0;
  endtask

  initial begin
    int q[$];
    int pushed, popped, cyc;
    logic mp, mq;
    logic [31:0] nin, nout;

    rstn = 1'b0; clr = 1'b0; din = '0; vin = 1'b0; rin = 1'b0;
    clr5 = 1'b0; d5 = '0; v5 = 1'b0; r5 = 1'b0;

    tbl[0]  = mk(0, 1, 32'h1, 0, 1, 1, 32'h1, 1, 0, 1);
    tbl[1]  = mk(0, 1, 32'h2, 0, 2, 1, 32'h1, 1, 0, 1);
    tbl[2]  = mk(0, 1, 32'h3, 0, 3, 1, 32'h1, 1, 0, 0);
    tbl[3]  = mk(0, 1, 32'h4, 0, 4, 1, 32'h1, 1, 0, 0);
    tbl[4]  = mk(0, 1, 32'h5, 0, 5, 1, 32'h1, 1, 0, 0);
    tbl[5]  = mk(0, 1, 32'h6, 0, 6, 1, 32'h1, 1, 1, 0);
    tbl[6]  = mk(0, 1, 32'h7, 0, 7, 1, 32'h1, 1, 1, 0);
    tbl[7]  = mk(0, 1, 32'h8, 0, 8, 1, 32'h1, 0, 1, 0);
    tbl[8]  = mk(0, 1, 32'h9, 0, 8, 1, 32'h1, 0, 1, 0);
    tbl[9]  = mk(0, 0, 32'h0, 1, 7, 1, 32'h2, 1, 1, 0);
    tbl[10] = mk(0, 0, 32'h0, 1, 6, 1, 32'h3, 1, 1, 0);
    tbl[11] = mk(0, 0, 32'h0, 1, 5, 1, 32'h4, 1, 0, 0);
    tbl[12] = mk(0, 0, 32'h0, 1, 4, 1, 32'h5, 1, 0, 0);
    tbl[13] = mk(0, 0, 32'h0, 1, 3, 1, 32'h6, 1, 0, 0);
    tbl[14] = mk(0, 0, 32'h0, 1, 2, 1, 32'h7, 1, 0, 1);
    tbl[15] = mk(0, 0, 32'h0, 1, 1, 1, 32'h8, 1, 0, 1);
    tbl[16] = mk(0, 0, 32'h0, 1, 0, 0, 32'h0, 1, 0, 1);
    tbl[17] = mk(0, 0, 32'h0, 1, 0, 0, 32'h0, 1, 0, 1);
    tbl[18] = mk(0, 1, 32'h55, 1, 1, 1, 32'h55, 1, 0, 1);
    tbl[19] = mk(1, 1, 32'h66, 0, 0, 0, 32'h0, 1, 0, 1);

    #12;
    chk("rst lvl", 32'(lvl), 32'd0);
    chk("rst rdy", 32'(rdy), 32'd1);
    chk("rst vout", 32'(vout), 32'd0);
    chk("rst af", 32'(af), 32'd0);
    chk("rst ae", 32'(ae), 32'd1);
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      clr = tbl[i].clr; vin = tbl[i].vin;
      din = tbl[i].din; rin = tbl[i].rin;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d lvl", i), 32'(lvl), 32'(tbl[i].lvl));
      chk($sformatf("v%0d vout", i), 32'(vout), 32'(tbl[i].vout));
      chk($sformatf("v%0d rdy", i), 32'(rdy), 32'(tbl[i].rdy));
      chk($sformatf("v%0d af", i), 32'(af), 32'(tbl[i].af));
      chk($sformatf("v%0d ae", i), 32'(ae), 32'(tbl[i].ae));
      if (tbl[i].vout)
        chk($sformatf("v%0d dout", i), dout, tbl[i].dout);
    end
    @(negedge clk);
    clr = 1'b0; vin = 1'b0; rin = 1'b0;

    // first-word latency on an empty FIFO
    @(negedge clk);
    vin = 1'b1; din = 32'hA5A5A5A5;
    #1;
    chk("lat pre vout", 32'(vout), 32'd0);
    @(posedge clk);
    #1;
    chk("lat post vout", 32'(vout), 32'd1);
    chk("lat post dout", dout, 32'hA5A5A5A5);
    @(negedge clk);
    vin = 1'b0;
    clr_cycle();

    // steady push+pop at level 4 across pointer wrap
    push_n(32'h100, 4);
    chk("conc start lvl", 32'(lvl), 32'd4);
    nin = 32'h104; nout = 32'h100;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      vin = 1'b1; din = nin; rin = 1'b1;
      chk($sformatf("conc%0d dout", i), dout, nout);
      @(posedge clk);
      #1;
      chk($sformatf("conc%0d lvl", i), 32'(lvl), 32'd4);
      nin++; nout++;
    end
    @(negedge clk);
    vin = 1'b0; rin = 1'b0;
    chk("conc end dout", dout, nout);
    clr_cycle();

    // full: pop wins, push blocked
    push_n(32'h200, 8);
    chk("full lvl", 32'(lvl), 32'd8);
    chk("full rdy", 32'(rdy), 32'd0);
    @(negedge clk);
    vin = 1'b1; din = 32'hDEAD; rin = 1'b1;
    @(posedge clk);
    #1;
    chk("fullpp lvl", 32'(lvl), 32'd7);
    chk("fullpp dout", dout, 32'h201);
`ifdef SPI_SLAVE_FIFO_ERR_EN
    chk("fullpp ovf", 32'(ovf), 32'd1);
`endif
    @(negedge clk);
    vin = 1'b0; rin = 1'b0;
    clr_cycle();
`ifdef SPI_SLAVE_FIFO_ERR_EN
    chk("clr ovf", 32'(ovf), 32'd0);
`endif

    // flush overrides a same-cycle push
    push_n(32'h300, 5);
    chk("flush pre lvl", 32'(lvl), 32'd5);
    @(negedge clk);
    clr = 1'b1; vin = 1'b1; din = 32'h3FF;
    @(posedge clk);
    #1;
    chk("flush lvl", 32'(lvl), 32'd0);
    chk("flush vout", 32'(vout), 32'd0);
    chk("flush rdy", 32'(rdy), 32'd1);
    @(negedge clk);
    clr = 1'b0; vin = 1'b0;

    // async reset mid-transfer
    push_n(32'h400, 3);
    @(negedge clk);
    vin = 1'b1; din = 32'h4FF; rin = 1'b1;
    #2;
    rstn = 1'b0;
    #1;
    chk("arst lvl", 32'(lvl), 32'd0);
    chk("arst vout", 32'(vout), 32'd0);
    chk("arst rdy", 32'(rdy), 32'd1);
    chk("arst af", 32'(af), 32'd0);
    chk("arst ae", 32'(ae), 32'd1);
    @(negedge clk);
    vin = 1'b0; rin = 1'b0;
    @(negedge clk);
    rstn = 1'b1;

    // depth-5 instance: 13 words through a non-power-of-two ring
    pushed = 0; popped = 0; cyc = 0;
    while (popped < 13 && cyc < 200) begin
      @(negedge clk);
      v5 = (pushed < 13);
      d5 = 8'(pushed + 1);
      r5 = (cyc >= 7) && ((cyc % 4) != 3);
      mp = v5 && (q.size() < 5);
      mq = r5 && (q.size() > 0);
      if (mq) chk($sformatf("d5 pop%0d", popped), 32'(dout5), 32'(q[0]));
      @(posedge clk);
      #1;
      if (mq) begin
        void'(q.pop_front());
        popped++;
      end
      if (mp) begin
        q.push_back(pushed + 1);
        pushed++;
      end
      chk($sformatf("d5 lvl c%0d", cyc), 32'(lvl5), 32'(q.size()));
      chk($sformatf("d5 bound c%0d", cyc), 32'(lvl5 > 3'd5), 32'd0);
      if (cyc == 5) chk("d5 full rdy", 32'(rdy5), 32'd0);
      cyc++;
    end
    @(negedge clk);
    v5 = 1'b0; r5 = 1'b0;
    chk("d5 done", 32'(popped), 32'd13);
    chk("d5 end vout", 32'(vout5), 32'd0);
    chk("d5 end ae", 32'(ae5), 32'd1);
    chk("d5 end af", 32'(af5), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
